// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART transmit scheduler.
// Holds the FSM state encoding and default sizing.
package spart_pkg;

  localparam int DATA_W           = 8;
  localparam int DEF_N_REQ        = 4;
  localparam int DEF_LOCK_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_LOW,
    ST_WAIT_HIGH
  } state_t;

endpackage

// File: rtl/spart_tx_sched_rr_picker.sv
// Round-robin picker: first set request strictly after ptr,
// wrapping, with ptr itself checked last.
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic                 valid
);

  localparam int W = $clog2(N);

  logic [W-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = W'((int'(ptr) + k) % N);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spart_tx_sched.sv
// Byte scheduler feeding a SPART transmitter from N requesters,
// with round-robin arbitration and per-packet locking.
module spart_tx_sched
  import spart_pkg::*;
#(
  parameter int N_REQ        = DEF_N_REQ,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [DATA_W*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0]          req_mask,
  output logic                      tx_en,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_tbr,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic                      lock_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic              lock_q, lock_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              wl_q, wl_d;

  logic [N_REQ-1:0]  elig, gnt, owner_oh;
  logic              gnt_vld, idle, xfer;
  logic [IW-1:0]     win_id;
  logic [DATA_W-1:0] win_data;
  logic              win_last;

  // While locked, only the owner may compete.
  assign owner_oh = N_REQ'(1) << grant_q;
  assign elig     = (req_valid & ~req_mask)
                  & (lock_q ? owner_oh : {N_REQ{1'b1}});

  rr_picker #(.N(N_REQ)) u_pick (
    .req   (elig),
    .ptr   (grant_q),
    .gnt   (gnt),
    .valid (gnt_vld)
  );

  always_comb begin
    win_id   = '0;
    win_data = '0;
    win_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        win_id   = IW'(i);
        win_data = req_data[DATA_W*i +: DATA_W];
        win_last = req_last[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (xfer) state_d = ST_LOAD;
      ST_LOAD:      state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: begin
        if (!tx_tbr)  state_d = ST_WAIT_HIGH;
        else if (wl_q) state_d = ST_IDLE;
      end
      ST_WAIT_HIGH: if (tx_tbr) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idle      = (state_q == ST_IDLE);
    busy      = !idle;
    tx_en     = (state_q == ST_LOAD);
    req_ready = (idle && tx_tbr && gnt_vld) ? gnt : '0;
    xfer      = |(req_ready & req_valid);
  end

  always_comb begin
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    lock_d    = lock_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    wl_d      = (state_q == ST_WAIT_LOW);
    if (xfer) begin
      tx_data_d = win_data;
      grant_d   = win_id;
      lock_d    = !win_last;
      cnt_d     = '0;
    end else if (idle && lock_q) begin
      // A masked owner drops the lock quietly; a silent one times out.
      if (req_mask[grant_q]) begin
        lock_d = 1'b0;
        cnt_d  = '0;
      end else if (!req_valid[grant_q]) begin
        if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          lock_d = 1'b0;
          cnt_d  = '0;
          err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q <= '0;
      grant_q   <= IW'(N_REQ - 1);
      lock_q    <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      wl_q      <= 1'b0;
    end else begin
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
      lock_q    <= lock_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      wl_q      <= wl_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;
  assign lock_err = err_q;

endmodule

// File: tb/tb_spart_tx_sched.sv
// Bench for spart_tx_sched: requester queues, a transmitter model
// and a scoreboard of expected {grant_id, tx_data} per tx_en.
module tb_spart_tx_sched;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid, req_last, req_mask, req_ready;
  logic [31:0]  req_data;
  logic         tx_en, tx_tbr, busy, lock_err;
  logic [7:0]   tx_data;
  logic [1:0]   grant_id;

  always #5 clk = ~clk;

  spart_tx_sched #(.N_REQ(4), .LOCK_TIMEOUT(255)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .req_mask  (req_mask),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .tx_tbr    (tx_tbr),
    .grant_id  (grant_id),
    .busy      (busy),
    .lock_err  (lock_err)
  );

  typedef struct packed { logic [7:0] d; logic l; } byte_t;
  typedef struct packed { logic [1:0] id; logic [7:0] d; } exp_t;
  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  mask;
    int          nb;
    int          n;
    logic [31:0] order;
    logic [7:0]  base;
  } row_t;

  byte_t rq [N][$];
  exp_t  exp_q[$];
  row_t  rows[6];

  int checks = 0, failures = 0;
  int err_count = 0, txen_count = 0, tbr_cnt = 0;
  logic tbr_auto;
  logic s_busy, s_err, s_txen;
  logic [3:0] s_ready;
  logic [1:0] s_grant;
  logic [7:0] s_data;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = rq[i][0].d;
        req_last[i]       = rq[i][0].l;
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [3:0] hs;
    exp_t e;
    @(negedge clk);
    hs      = req_valid & req_ready;
    s_busy  = busy;
    s_ready = req_ready;
    s_err   = lock_err;
    s_grant = grant_id;
    s_data  = tx_data;
    s_txen  = tx_en;
    if (lock_err) err_count++;
    if (tx_en) begin
      txen_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected: got id %0d data %0h expected none",
                 grant_id, tx_data);
      end else begin
        e = exp_q.pop_front();
        chk("tx_byte", {22'd0, grant_id, tx_data}, {22'd0, e.id, e.d});
      end
    end
    @(posedge clk);
    #1;
    if (rst) hs = '0;
    for (int i = 0; i < N; i++)
      if (hs[i]) void'(rq[i].pop_front());
    if (tbr_auto) begin
      if (s_txen) begin
        tx_tbr  = 1'b0;
        tbr_cnt = 4;
      end else if (!tx_tbr) begin
        tbr_cnt--;
        if (tbr_cnt == 0) tx_tbr = 1'b1;
      end
    end
    drive();
  endtask

  task automatic drain(int max);
    int g = 0;
    while ((exp_q.size() != 0 || s_busy) && g < max) begin
      step();
      g++;
    end
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_idle", {31'd0, s_busy}, 0);
  endtask

  task automatic wait_tx(int max);
    int g = 0;
    while (exp_q.size() != 0 && g < max) begin
      step();
      g++;
    end
    chk("tx_seen", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_cnt;
    int g;
    int t0;

    // valid, mask, bytes each, count, order (first in low nibble), base
    rows[0] = '{4'b0101, 4'b0000, 1, 2, 32'h20,   8'h01};
    rows[1] = '{4'b1111, 4'b0101, 2, 4, 32'h1313, 8'h02};
    rows[2] = '{4'b1111, 4'b0000, 1, 4, 32'h1032, 8'h03};
    rows[3] = '{4'b1001, 4'b0000, 1, 2, 32'h03,   8'h04};
    rows[4] = '{4'b0010, 4'b1101, 1, 1, 32'h1,    8'h05};
    rows[5] = '{4'b0001, 4'b0000, 1, 1, 32'h0,    8'h06};

    rst      = 1'b1;
    tx_tbr   = 1'b1;
    tbr_auto = 1'b1;
    req_mask = '0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    drive();
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_busy",  {31'd0, s_busy}, 0);
    chk("rst_tx_en", {31'd0, s_txen}, 0);
    chk("rst_data",  {24'd0, s_data}, 0);
    chk("rst_grant", {30'd0, s_grant}, 3);
    chk("rst_err",   {31'd0, s_err}, 0);
    chk("rst_ready", {28'd0, s_ready}, 0);

    for (int r = 0; r < 6; r++) begin
      int cnt[N];
      logic [1:0] id;
      for (int i = 0; i < N; i++) cnt[i] = 0;
      req_mask = rows[r].mask;
      for (int i = 0; i < N; i++)
        if (rows[r].valid[i])
          for (int j = 0; j < rows[r].nb; j++)
            rq[i].push_back({8'(rows[r].base + 16*i + j), 1'b1});
      for (int k = 0; k < rows[r].n; k++) begin
        id = rows[r].order[4*k +: 2];
        exp_q.push_back({id, 8'(rows[r].base + 16*id + cnt[id])});
        cnt[id]++;
      end
      drive();
      drain(200);
      for (int i = 0; i < N; i++) rq[i].delete();
      drive();
    end
    req_mask = '0;

    // 3-byte locked packet from req 1 ahead of req 3
    rq[1].push_back({8'h81, 1'b0});
    rq[1].push_back({8'h82, 1'b0});
    rq[1].push_back({8'h83, 1'b1});
    rq[3].push_back({8'h91, 1'b1});
    exp_q.push_back({2'd1, 8'h81});
    exp_q.push_back({2'd1, 8'h82});
    exp_q.push_back({2'd1, 8'h83});
    exp_q.push_back({2'd3, 8'h91});
    drive();
    drain(100);

    // lock timeout on a silent owner
    rq[2].push_back({8'h55, 1'b0});
    exp_q.push_back({2'd2, 8'h55});
    drive();
    wait_tx(20);
    rq[0].push_back({8'h5A, 1'b1});
    exp_q.push_back({2'd0, 8'h5A});
    drive();
    idle_cnt = 0;
    g = 0;
    while (g < 400) begin
      step();
      g++;
      if (s_err) break;
      if (!s_busy) begin
        idle_cnt++;
        if (idle_cnt == 100) chk("locked_no_grant", {28'd0, s_ready}, 0);
      end
    end
    chk("timeout_cycles", idle_cnt, 255);
    chk("timeout_err_seen", {31'd0, s_err}, 1);
    chk("timeout_grant0", {28'd0, s_ready}, 4'b0001);
    drain(50);
    chk("err_once", err_count, 1);

    // owner masked while locked: lock drops without lock_err
    rq[1].push_back({8'h61, 1'b0});
    exp_q.push_back({2'd1, 8'h61});
    drive();
    wait_tx(20);
    req_mask = 4'b0010;
    rq[3].push_back({8'h63, 1'b1});
    exp_q.push_back({2'd3, 8'h63});
    drive();
    drain(60);
    chk("mask_no_err", err_count, 1);
    req_mask = '0;

    // transmitter never responds
    tbr_auto = 1'b0;
    tx_tbr   = 1'b1;
    t0 = txen_count;
    rq[0].push_back({8'hA5, 1'b1});
    exp_q.push_back({2'd0, 8'hA5});
    drive();
    wait_tx(20);
    step();
    chk("nr_busy1", {31'd0, s_busy}, 1);
    step();
    chk("nr_busy2", {31'd0, s_busy}, 1);
    step();
    chk("nr_idle", {31'd0, s_busy}, 0);
    chk("nr_data_hold", {24'd0, s_data}, 8'hA5);
    chk("nr_single_en", txen_count - t0, 1);
    tbr_auto = 1'b1;

    // reset while waiting for the stop bit
    rq[2].push_back({8'h3C, 1'b1});
    exp_q.push_back({2'd2, 8'h3C});
    drive();
    wait_tx(20);
    step();
    chk("wh_busy", {31'd0, s_busy}, 1);
    rst = 1'b1;
    step();
    rst     = 1'b0;
    tx_tbr  = 1'b1;
    tbr_cnt = 0;
    step();
    chk("abort_busy",  {31'd0, s_busy}, 0);
    chk("abort_tx_en", {31'd0, s_txen}, 0);
    chk("abort_grant", {30'd0, s_grant}, 3);
    rq[2].push_back({8'h77, 1'b1});
    rq[0].push_back({8'h66, 1'b1});
    exp_q.push_back({2'd0, 8'h66});
    exp_q.push_back({2'd2, 8'h77});
    drive();
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spart_tx_sched.md
SPART_TX_SCHED -- requirements
Module: spart_tx_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4, the number of requesters (2..8).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 255, the idle cycles before a packet lock is forcibly released.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester byte valid.
REQ-006 SHALL have port req_data  input  8*N_REQ  per-requester byte; requester i owns bits [8i+7:8i].
REQ-007 SHALL have port req_last  input  N_REQ  marks the final byte of a packet.
REQ-008 SHALL have port req_ready  output  N_REQ  per-requester accept, one-hot or zero.
REQ-009 SHALL have port req_mask  input  N_REQ  a 1 excludes the requester from arbitration.
REQ-010 SHALL have port tx_en  output  1  single-cycle load strobe to the transmitter.
REQ-011 SHALL have port tx_data  output  8  byte to the transmitter.
REQ-012 SHALL have port tx_tbr  input  1  transmitter buffer ready; goes low the cycle after a load and returns high after the stop bit.
REQ-013 SHALL have port grant_id  output  clog2(N_REQ)  requester owning the current or last byte.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port lock_err  output  1  one-cycle pulse when a lock times out.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, WAIT_LOW and WAIT_HIGH.
REQ-017 In IDLE with tx_tbr=1, the block SHALL drive req_ready high combinationally only for the winner, the first unmasked valid requester after grant_id in round-robin order.
REQ-018 While locked, the winner SHALL be the lock owner only; no other requester is ready.
REQ-019 A byte transfer occurs when req_valid[i] and req_ready[i] are both high; tx_data and grant_id SHALL register on that edge and the FSM SHALL move to LOAD.
REQ-020 In LOAD, tx_en SHALL be 1 for exactly one cycle, the cycle after the transfer; the FSM then moves to WAIT_LOW.
REQ-021 WAIT_LOW SHALL wait for tx_tbr=0; if tx_tbr is still 1 after 2 cycles, the FSM SHALL return to IDLE (no transmitter response).
REQ-022 WAIT_HIGH SHALL wait for tx_tbr=1, then return to IDLE; the next transfer is possible in that same IDLE cycle.
REQ-023 tx_data SHALL hold its value from transfer until the next transfer.
REQ-024 A transfer with req_last=0 SHALL set the lock to grant_id; a transfer with req_last=1 SHALL clear the lock.
REQ-025 While locked in IDLE with the owner's valid low, a counter SHALL increment; at LOCK_TIMEOUT the lock SHALL clear, lock_err SHALL pulse and the counter SHALL zero.
REQ-026 The timeout counter SHALL zero on every transfer.
REQ-027 If the lock owner becomes masked, the lock SHALL clear in the next cycle, with no lock_err.
REQ-028 With no unmasked valid requester, the FSM SHALL stay in IDLE, req_ready=0 and the round-robin pointer SHALL be unchanged.
REQ-029 The round-robin pointer SHALL wrap from N_REQ-1 to 0.
REQ-030 Changes to req_mask in non-IDLE states SHALL take effect at the next IDLE arbitration only.

Reset
REQ-031 On rst, the FSM SHALL go to IDLE with tx_en=0, tx_data=0, grant_id=N_REQ-1 (so requester 0 wins first), lock cleared, counter=0, lock_err=0 and busy=0.
REQ-032 rst asserted mid-frame SHALL abort immediately; no tx_en SHALL issue in the following cycle.

Structure
REQ-033 A shared package spart_pkg SHALL hold the FSM state enum, the data width (8) and the default N_REQ/LOCK_TIMEOUT constants.
REQ-034 Round-robin selection SHALL live in sub-module rr_picker (inputs request vector and pointer; outputs one-hot winner and valid).

Verification
REQ-035 Req 0 and 2 valid with last=1 after reset -> req 0 transfers first, tx_en one cycle later, then req 2 after tx_tbr rises; grant_id 0 then 2.
REQ-036 Req 1 sends a 3-byte packet (last on byte 3) while req 3 is valid -> bytes 1,1,1 are sent before any req 3 byte.
REQ-037 Locked req 2 drops valid for 255 IDLE cycles -> lock_err pulses once and req 0 is granted on the next cycle.
REQ-038 Transfer 0xA5, then tx_tbr held at 1 -> tx_en=1 once, FSM back in IDLE 2 cycles after LOAD, busy=0.
REQ-039 rst pulsed in WAIT_HIGH -> busy=0 and tx_en=0 next cycle; first grant after reset goes to requester 0.
REQ-040 All requesters valid with req_mask=4'b0101 -> only requesters 1 and 3 are granted, alternating.
